// File: rtl/pc_stack.sv
// Hack CPU program counter with an integrated hardware return-address stack.
// Supports load/inc/hold, single-cycle call/ret, soft clear and sticky stack error flags.
module pc_stack #(
    parameter int unsigned     WIDTH        = 15,
    parameter int unsigned     DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned     SPW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   sp_count,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] out_q, out_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             push;
    logic [WIDTH-1:0] ret_addr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             empty;
    logic             full;
    logic [WIDTH-1:0] top_entry;

    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SPW'(DEPTH));
    assign ret_addr  = out_q + 1'b1;
    assign wr_idx    = sp_q[AW-1:0];
    assign top_idx   = wr_idx - 1'b1;
    assign top_entry = empty ? '0 : stack_q[top_idx];

    always_comb begin
        out_d = out_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (clr) begin
            out_d = RESET_VECTOR;
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            // err_clr applied first so a same-cycle error re-sets the flag
            if (err_clr) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (call) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    sp_d  = sp_q + 1'b1;
                    out_d = in;
                end
            end else if (ret) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    out_d = top_entry;
                    sp_d  = sp_q - 1'b1;
                end
            end else if (load) begin
                out_d = in;
            end else if (inc) begin
                out_d = out_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= RESET_VECTOR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage has no reset; entries above sp_count are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[wr_idx] <= ret_addr;
        end
    end

    assign out           = out_q;
    assign top           = top_entry;
    assign sp_count      = sp_q;
    assign stack_empty   = empty;
    assign stack_full    = full;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (WIDTH=15, DEPTH=4, RESET_VECTOR=0).
module tb_pc_stack;

    localparam int unsigned WIDTH = 15;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SPW   = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clr, load, inc, call, ret, err_clr;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out, top;
    logic [SPW-1:0]   sp_count;
    logic             stack_empty, stack_full, overflow_err, underflow_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_VECTOR(15'h0000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clr(clr),
        .load(load),
        .inc(inc),
        .call(call),
        .ret(ret),
        .err_clr(err_clr),
        .in(in),
        .out(out),
        .top(top),
        .sp_count(sp_count),
        .stack_empty(stack_empty),
        .stack_full(stack_full),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr = 0; load = 0; inc = 0; call = 0; ret = 0; err_clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 0; in = '0;
        idle();
        #12;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_sp", 32'(sp_count), 32'h0);
        chk("rst_empty", 32'(stack_empty), 32'h1);
        chk("rst_full", 32'(stack_full), 32'h0);
        chk("rst_ovf", 32'(overflow_err), 32'h0);
        chk("rst_unf", 32'(underflow_err), 32'h0);
        chk("rst_top", 32'(top), 32'h0);
        reset_n = 1;

        // increment then load, then hold
        inc = 1; cyc(); chk("inc1", 32'(out), 32'h1);
        inc = 1; cyc(); chk("inc2", 32'(out), 32'h2);
        inc = 1; cyc(); chk("inc3", 32'(out), 32'h3);
        load = 1; in = 15'h2AAA; cyc(); chk("load", 32'(out), 32'h2AAA);
        in = 15'h1111; cyc(); chk("hold", 32'(out), 32'h2AAA);
        load = 1; inc = 1; in = 15'h0333; cyc(); chk("load_over_inc", 32'(out), 32'h0333);

        // nested calls and returns
        load = 1; in = 15'h0010; cyc();
        call = 1; in = 15'h0100; cyc();
        chk("call1_out", 32'(out), 32'h0100);
        chk("call1_top", 32'(top), 32'h0011);
        call = 1; in = 15'h0200; cyc();
        chk("call2_out", 32'(out), 32'h0200);
        chk("call2_sp", 32'(sp_count), 32'h2);
        chk("call2_top", 32'(top), 32'h0101);
        ret = 1; cyc();
        chk("ret1_out", 32'(out), 32'h0101);
        chk("ret1_sp", 32'(sp_count), 32'h1);
        ret = 1; cyc();
        chk("ret2_out", 32'(out), 32'h0011);
        chk("ret2_empty", 32'(stack_empty), 32'h1);
        chk("ret2_top", 32'(top), 32'h0);

        // overflow: pushes 0012, 1001, 1002, 1003
        for (int i = 0; i < 4; i++) begin
            call = 1; in = 15'(32'h1000 + i); cyc();
        end
        chk("fill_full", 32'(stack_full), 32'h1);
        chk("fill_sp", 32'(sp_count), 32'h4);
        chk("fill_top", 32'(top), 32'h1003);
        call = 1; in = 15'h7000; cyc();
        chk("ovf_out", 32'(out), 32'h1003);
        chk("ovf_sp", 32'(sp_count), 32'h4);
        chk("ovf_flag", 32'(overflow_err), 32'h1);
        chk("ovf_top", 32'(top), 32'h1003);
        cyc(); chk("ovf_sticky", 32'(overflow_err), 32'h1);
        err_clr = 1; cyc(); chk("ovf_cleared", 32'(overflow_err), 32'h0);
        err_clr = 1; call = 1; in = 15'h7000; cyc();
        chk("ovf_set_wins", 32'(overflow_err), 32'h1);
        err_clr = 1; cyc(); chk("ovf_cleared2", 32'(overflow_err), 32'h0);

        // drain in LIFO order
        ret = 1; cyc(); chk("pop1", 32'(out), 32'h1003);
        ret = 1; cyc(); chk("pop2", 32'(out), 32'h1002);
        ret = 1; cyc(); chk("pop3", 32'(out), 32'h1001);
        ret = 1; cyc(); chk("pop4", 32'(out), 32'h0012);
        chk("pop4_empty", 32'(stack_empty), 32'h1);

        // underflow and call/ret together
        ret = 1; cyc();
        chk("unf_out", 32'(out), 32'h0012);
        chk("unf_flag", 32'(underflow_err), 32'h1);
        chk("unf_sp", 32'(sp_count), 32'h0);
        load = 1; in = 15'h0020; cyc();
        call = 1; ret = 1; in = 15'h0050; cyc();
        chk("cr_out", 32'(out), 32'h0050);
        chk("cr_top", 32'(top), 32'h0021);
        chk("cr_sp", 32'(sp_count), 32'h1);
        chk("cr_unf", 32'(underflow_err), 32'h1);
        clr = 1; load = 1; in = 15'h1234; cyc();
        chk("clr_out", 32'(out), 32'h0);
        chk("clr_sp", 32'(sp_count), 32'h0);
        chk("clr_unf", 32'(underflow_err), 32'h0);
        chk("clr_ovf", 32'(overflow_err), 32'h0);

        // raise underflow again so the async reset has a flag to clear
        ret = 1; cyc(); chk("unf2_flag", 32'(underflow_err), 32'h1);

        // wrap
        load = 1; in = 15'h7FFF; cyc();
        inc = 1; cyc(); chk("inc_wrap", 32'(out), 32'h0);
        load = 1; in = 15'h7FFF; cyc();
        call = 1; in = 15'h0005; cyc();
        chk("callwrap_top", 32'(top), 32'h0);
        chk("callwrap_out", 32'(out), 32'h0005);

        // async reset mid-call with sp_count=3
        call = 1; in = 15'h0400; cyc();
        call = 1; in = 15'h0500; cyc();
        chk("pre_rst_sp", 32'(sp_count), 32'h3);
        chk("pre_rst_top", 32'(top), 32'h0401);
        call = 1; in = 15'h0600;
        #2;
        reset_n = 0;
        #1;
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_sp", 32'(sp_count), 32'h0);
        chk("arst_empty", 32'(stack_empty), 32'h1);
        chk("arst_unf", 32'(underflow_err), 32'h0);
        chk("arst_ovf", 32'(overflow_err), 32'h0);
        chk("arst_top", 32'(top), 32'h0);
        cyc();
        chk("arst_held", 32'(out), 32'h0);
        reset_n = 1;
        inc = 1; cyc(); chk("post_rst_inc", 32'(out), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
